mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the number of grant cycles without RAM completion before the timeout flag sets.
REQ-002 SHALL have ports, one per line as below:
- CLK  in  1  clock; all state changes on its rising edge.
- nRST  in  1  reset; synchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iload  out  32  instruction read data.
- iwait  out  1  instruction requester stall.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data.
- dwait  out  1  data requester stall.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM state: FREE, BUSY, ACCESS or ERROR.
- tmo_err  out  1  sticky timeout flag.

Function
REQ-003 SHALL implement FSM states IDLE, GNT_I and GNT_D.
REQ-004 IDLE: with dREN|dWEN pending, go to GNT_D; else with iREN, go to GNT_I; else stay. Selection is registered, so arbitration costs 1 cycle.
REQ-005 GNT_D: drive ramaddr=daddr and ramstore=dstore; ramWEN=dWEN; ramREN=dREN&~dWEN, so a write wins when both are set.
REQ-006 GNT_I: drive ramREN=1, ramWEN=0, ramaddr=iaddr.
REQ-007 Outside a grant: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-008 iload and dload SHALL equal ramload combinationally at all times.
REQ-009 Wait outputs: iwait=~(GNT_I & ramstate==ACCESS); dwait=~(GNT_D & ramstate==ACCESS). Completion is visible in the same cycle.
REQ-010 On completion (ACCESS in a grant state), go to IDLE. A back-to-back request is therefore re-granted after 1 idle cycle.
REQ-011 FREE, BUSY and ERROR in a grant state: hold the grant and keep the wait high. ERROR is retried indefinitely.
REQ-012 Abort: if the granted requester drops its request before completion, go to IDLE next cycle. The RAM enables are already low that cycle because they are qualified by the request.
REQ-013 A requester SHALL NOT be preempted while granted. A new dREN/dWEN during GNT_I waits for GNT_I to complete.
REQ-014 Watchdog counter (8 bits minimum, saturating): cleared on entry to a grant state; increments each grant cycle without ACCESS.
REQ-015 When the watchdog reaches TIMEOUT, set tmo_err. tmo_err stays set until reset; the grant continues.

Reset
REQ-016 With nRST low at a clock edge: state=IDLE, watchdog=0, tmo_err=0, all RAM enables low, iwait=dwait=1. This applies even mid-grant.
REQ-017 A request still asserted after reset releases SHALL be re-arbitrated from IDLE.

Configuration
REQ-018 Macro MEM_ARB_RR_EN:
- Defined: a last-grant bit is set when a grant completes, and when both requesters are pending in IDLE, the one not last served is chosen.
- Undefined: fixed data priority per REQ-004, and the last-grant bit is absent.

Structure
REQ-019 The arbiter state enum SHALL be added to cpu_types_pkg, reusing the existing ramstate_t and word_t.
REQ-020 The watchdog SHALL be a sub-module arb_watchdog (clear, enable, saturating count, sticky flag).

Verification
REQ-021 Reset mid-grant: nRST low in GNT_D -> next cycle IDLE, ramWEN=0, dwait=1, tmo_err=0.
REQ-022 Single read: iREN, iaddr=0x40, ACCESS after 3 cycles, ramload=0xDEADBEEF -> iwait low exactly 1 cycle with iload=0xDEADBEEF, then IDLE.
REQ-023 Contention: iREN and dWEN rise together, daddr=0x80, dstore=0x1234 -> GNT_D first with ramWEN=1 and ramstore=0x1234. GNT_I follows after completion plus 1 idle cycle.
REQ-024 Round-robin with MEM_ARB_RR_EN defined: both requesters held continuously -> grants alternate D, I, D, I. With the macro undefined -> D only, while dWEN is held.
REQ-025 Abort: dREN dropped on the 2nd cycle of GNT_D -> ramREN=0 that cycle, IDLE next cycle, no dwait low pulse.
REQ-026 Timeout: TIMEOUT=4, ramstate held BUSY -> tmo_err rises on the 4th grant cycle and stays high. ACCESS later still completes normally.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Package   : cpu_types_pkg
// Purpose   : Shared CPU-side types: data word, RAM handshake state and the
//             memory arbiter state encoding, plus a watchdog width helper.
// Revision  : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM handshake state reported by the memory model/controller
  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  // Memory arbiter FSM encoding (explicit 2-bit values)
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_t;

  // Watchdog counter width: wide enough to hold TIMEOUT, never below 8 bits
  function automatic int wdog_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module    : arb_watchdog
// Purpose   : Saturating grant-cycle counter with a sticky timeout flag. The
//             flag sets on the edge where the count reaches TIMEOUT and is
//             only cleared by reset.
// Revision  : 1.0 - initial release
// ============================================================================
module arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic i_nrst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_flag
);

  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] C_CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_flag;

  // Next count: clear wins, otherwise saturating increment while enabled
  always_comb begin
    w_count_nxt = r_count;
    if (i_clear) begin
      w_count_nxt = '0;
    end else if (i_enable && (r_count != C_CNT_MAX)) begin
      w_count_nxt = r_count + 1'b1;
    end
  end

  // Count register and sticky flag; flag rises together with the count
  always_ff @(posedge clk) begin
    if (!i_nrst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (i_enable && !i_clear && (w_count_nxt >= C_CNT_LIMIT)) begin
        r_flag <= 1'b1;
      end
    end
  end

  assign o_flag = r_flag;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : mem_arbiter
// Purpose   : Two-requester (instruction/data) arbiter in front of a single
//             RAM port. Registered selection, non-preemptive grants, abort on
//             request drop, watchdog with sticky timeout flag.
// Options   : MEM_ARB_RR_EN - when defined, ties in IDLE go to the requester
//             not served last; otherwise data always has priority.
// Revision  : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        tmo_err
);

  localparam int C_WDOG_W = wdog_width(TIMEOUT);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       w_dreq;
  logic       w_ireq;
  logic       w_done;
  logic       w_in_grant;
  logic       w_pick_d;

  assign w_dreq     = dREN | dWEN;
  assign w_ireq     = iREN;
  assign w_done     = (ramstate == ACCESS);
  assign w_in_grant = (r_state != IDLE);

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  // Remember which side completed last so a tie goes to the other one
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_last_d <= 1'b0;
    end else if ((r_state == GNT_D) && w_done) begin
      r_last_d <= 1'b1;
    end else if ((r_state == GNT_I) && w_done) begin
      r_last_d <= 1'b0;
    end
  end

  assign w_pick_d = w_dreq & (~w_ireq | ~r_last_d);
`else
  assign w_pick_d = w_dreq;
`endif

  // Next-state: arbitrate from IDLE, leave a grant on completion or abort
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_dreq || w_ireq) begin
          w_state_nxt = w_pick_d ? GNT_D : GNT_I;
        end
      end
      GNT_D: begin
        if (!w_dreq || w_done) begin
          w_state_nxt = IDLE;
        end
      end
      GNT_I: begin
        if (!w_ireq || w_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RAM-side drive; enables are qualified by the live request so an abort
  // never issues a stray access in the cycle the request drops
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (r_state)
      GNT_D: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;
  assign iwait = ~((r_state == GNT_I) && w_done);
  assign dwait = ~((r_state == GNT_D) && w_done);

  // Watchdog is held clear outside a grant and counts stalled grant cycles
  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (C_WDOG_W)
  ) u_wdog (
    .clk      (CLK),
    .i_nrst   (nRST),
    .i_clear  (~w_in_grant),
    .i_enable (w_in_grant & ~w_done),
    .o_flag   (tmo_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : tb_mem_arbiter
// Purpose   : Self-checking bench for mem_arbiter. Expected RAM transactions
//             are queued when requests are driven and compared when the
//             arbiter reports completion.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TIMEOUT = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        tmo_err;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .tmo_err(tmo_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_d;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input bit is_d, input bit wen, input logic [31:0] addr,
                          input logic [31:0] data);
    exp_t e;
    e.is_d = is_d; e.wen = wen; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    next_cycle();
    next_cycle();
    nRST = 1'b1;
    sb.delete();
  endtask

  // Serve one RAM transaction: wait for the grant, hold `hold` for lat
  // grant cycles, then ACCESS with rdata and compare against the queue.
  task automatic do_access(input string name, input int lat, input ramstate_t hold,
                           input logic [31:0] rdata, input int exp_wait);
    int   waited;
    bit   got;
    exp_t e;
    waited = 0;
    got    = 1'b0;
    ramstate = hold;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) begin
        got = 1'b1;
        break;
      end
      waited++;
      next_cycle();
    end
    n_vec++;
    if (!got) begin
      n_miss++;
      $display("FAIL %s_grant: no grant seen, required within 16 cycles", name);
      return;
    end
    if (waited != exp_wait) begin
      n_miss++;
      $display("FAIL %s_arb_latency: got %0d cycles, required %0d", name, waited, exp_wait);
    end
    for (int j = 1; j <= lat; j++) begin
      if (j > 1) begin
        next_cycle();
        @(negedge CLK);
      end
      n_vec++;
      if ({iwait, dwait} !== 2'b11) begin
        n_miss++;
        $display("FAIL %s_stall_c%0d: iwait/dwait got %b required 11", name, j, {iwait, dwait});
      end
    end
    next_cycle();
    ramstate = ACCESS;
    ramload  = rdata;
    @(negedge CLK);
    n_vec++;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL %s_sb: completion with empty scoreboard", name);
      return;
    end
    e = sb.pop_front();
    if ({iwait, dwait, ramWEN, ramREN} !== {e.is_d, ~e.is_d, e.wen, ~e.wen}) begin
      n_miss++;
      $display("FAIL %s_ctrl: iwait,dwait,ramWEN,ramREN got %b required %b", name,
               {iwait, dwait, ramWEN, ramREN}, {e.is_d, ~e.is_d, e.wen, ~e.wen});
    end
    n_vec++;
    if (ramaddr !== e.addr) begin
      n_miss++;
      $display("FAIL %s_addr: got %h required %h", name, ramaddr, e.addr);
    end
    if (e.wen) begin
      n_vec++;
      if (ramstore !== e.data) begin
        n_miss++;
        $display("FAIL %s_store: got %h required %h", name, ramstore, e.data);
      end
    end
    n_vec++;
    if ((e.is_d ? dload : iload) !== rdata) begin
      n_miss++;
      $display("FAIL %s_load: got %h required %h", name, (e.is_d ? dload : iload), rdata);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge CLK);
    n_vec++;
    if ({ramREN, ramWEN, iwait, dwait, tmo_err} !== 5'b00110 || ramaddr !== 32'h0) begin
      n_miss++;
      $display("FAIL reset_state: REN,WEN,iw,dw,tmo got %b addr %h required 00110 addr 0",
               {ramREN, ramWEN, iwait, dwait, tmo_err}, ramaddr);
    end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h77; ramstate = BUSY;
    next_cycle();
    @(negedge CLK);
    n_vec++;
    if ({ramWEN, dwait} !== 2'b11) begin
      n_miss++;
      $display("FAIL rst_mid_grant: ramWEN,dwait got %b required 11", {ramWEN, dwait});
    end
    next_cycle();
    nRST = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (ramWEN !== 1'b1) begin
      n_miss++;
      $display("FAIL rst_mid_sync: ramWEN got %b required 1 before the edge", ramWEN);
    end
    next_cycle();
    nRST = 1'b1;
    @(negedge CLK);
    n_vec++;
    if ({ramWEN, dwait, tmo_err} !== 3'b010 || ramaddr !== 32'h0) begin
      n_miss++;
      $display("FAIL rst_mid_idle: ramWEN,dwait,tmo got %b addr %h required 010 addr 0",
               {ramWEN, dwait, tmo_err}, ramaddr);
    end
    next_cycle();
    @(negedge CLK);
    n_vec++;
    if ({ramWEN, ramaddr} !== {1'b1, 32'h80}) begin
      n_miss++;
      $display("FAIL rst_rearb: ramWEN %b addr %h required 1 addr 00000080", ramWEN, ramaddr);
    end
    next_cycle();
    dWEN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_single_read();
    apply_reset();
    iREN = 1'b1; iaddr = 32'h40;
    push_exp(1'b0, 1'b0, 32'h40, 32'h0);
    do_access("iread", 3, BUSY, 32'hDEADBEEF, 1);
    next_cycle();
    iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    n_vec++;
    if ({iwait, ramREN} !== 2'b10 || ramaddr !== 32'h0) begin
      n_miss++;
      $display("FAIL iread_idle: iwait,ramREN got %b addr %h required 10 addr 0",
               {iwait, ramREN}, ramaddr);
    end
  endtask

  task automatic test_data_read_error();
    dREN = 1'b1; daddr = 32'h100;
    push_exp(1'b1, 1'b0, 32'h100, 32'h0);
    do_access("dread_err", 2, ERROR, 32'hCAFEF00D, 0);
    next_cycle();
    dREN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_contention();
    apply_reset();
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
    push_exp(1'b1, 1'b1, 32'h80, 32'h1234);
    push_exp(1'b0, 1'b0, 32'h44, 32'h0);
    do_access("cont_d", 2, BUSY, 32'h0, 1);
    next_cycle();
    dWEN = 1'b0; ramstate = FREE;
    do_access("cont_i", 2, ERROR, 32'h55AA33CC, 1);
    next_cycle();
    iREN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    iREN = 1'b1; iaddr = 32'h200; dWEN = 1'b1; daddr = 32'h300; dstore = 32'hA5A5;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
      if (k % 2 == 0) push_exp(1'b1, 1'b1, 32'h300, 32'hA5A5);
      else            push_exp(1'b0, 1'b0, 32'h200, 32'h0);
`else
      push_exp(1'b1, 1'b1, 32'h300, 32'hA5A5);
`endif
    end
    for (int k = 0; k < 4; k++) begin
      do_access("b2b", 1, BUSY, 32'h1000_0000 + k, 1);
      next_cycle();
      ramstate = FREE;
    end
    iREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic test_abort();
    apply_reset();
    dREN = 1'b1; daddr = 32'h600; ramstate = BUSY;
    next_cycle();
    @(negedge CLK);
    n_vec++;
    if ({ramREN, dwait} !== 2'b11 || ramaddr !== 32'h600) begin
      n_miss++;
      $display("FAIL abort_gnt: ramREN,dwait got %b addr %h required 11 addr 00000600",
               {ramREN, dwait}, ramaddr);
    end
    next_cycle();
    dREN = 1'b0;
    @(negedge CLK);
    n_vec++;
    if ({ramREN, dwait} !== 2'b01) begin
      n_miss++;
      $display("FAIL abort_drop: ramREN,dwait got %b required 01", {ramREN, dwait});
    end
    next_cycle();
    iREN = 1'b1; iaddr = 32'h640;
    @(negedge CLK);
    n_vec++;
    if ({ramREN, dwait} !== 2'b01 || ramaddr !== 32'h0) begin
      n_miss++;
      $display("FAIL abort_idle: ramREN,dwait got %b addr %h required 01 addr 0",
               {ramREN, dwait}, ramaddr);
    end
    next_cycle();
    @(negedge CLK);
    n_vec++;
    if ({ramREN, iwait} !== 2'b11 || ramaddr !== 32'h640) begin
      n_miss++;
      $display("FAIL abort_regrant: ramREN,iwait got %b addr %h required 11 addr 00000640",
               {ramREN, iwait}, ramaddr);
    end
    next_cycle();
    iREN = 1'b0; ramstate = FREE;
  endtask

  task automatic test_timeout();
    bit got;
    apply_reset();
    iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (ramREN) begin
        got = 1'b1;
        break;
      end
      next_cycle();
    end
    n_vec++;
    if (!got) begin
      n_miss++;
      $display("FAIL tmo_grant: no grant seen, required within 16 cycles");
      return;
    end
    // The flag is registered at the edge closing the TIMEOUT-th stalled
    // grant cycle, so it is first observed in grant cycle TIMEOUT+1.
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) begin
        next_cycle();
        @(negedge CLK);
      end
      n_vec++;
      if ({ramREN, iwait, tmo_err} !== {2'b11, (k > TIMEOUT)}) begin
        n_miss++;
        $display("FAIL tmo_c%0d: ramREN,iwait,tmo got %b required %b", k,
                 {ramREN, iwait, tmo_err}, {2'b11, (k > TIMEOUT)});
      end
    end
    next_cycle();
    ramstate = ACCESS; ramload = 32'h0BADF00D;
    @(negedge CLK);
    n_vec++;
    if ({iwait, tmo_err} !== 2'b01 || iload !== 32'h0BADF00D) begin
      n_miss++;
      $display("FAIL tmo_done: iwait,tmo got %b iload %h required 01 iload 0badf00d",
               {iwait, tmo_err}, iload);
    end
    next_cycle();
    iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    n_vec++;
    if ({ramREN, iwait, tmo_err} !== 3'b011) begin
      n_miss++;
      $display("FAIL tmo_sticky: ramREN,iwait,tmo got %b required 011", {ramREN, iwait, tmo_err});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation did not finish, required completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    test_reset();
    test_reset_mid_grant();
    test_single_read();
    test_data_read_error();
    test_contention();
    test_back_to_back();
    test_abort();
    test_timeout();
    n_vec++;
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
